// File: rtl/acq_pkg.sv
// Shared constants and types for the ADC acquisition path.
package acq_pkg;
    localparam int ADC_DATA_W     = 8;
    localparam int ACQ_DIV        = 10;
    localparam int ACQ_CAP_PHASE  = 7;
    localparam int ACQ_PIPE_LAT   = 3;
    localparam int ACQ_FIFO_DEPTH = 16;
    localparam int ACQ_WORD_W     = 2 * ADC_DATA_W;

    typedef enum logic {
        PK_LOW  = 1'b0,
        PK_HIGH = 1'b1
    } pack_state_t;
endpackage

// File: rtl/acq_sync_fifo.sv
// Show-ahead synchronous FIFO; the head word is visible whenever not empty.
module acq_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign level    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (level == (AW + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/adc_capture_packer.sv
// ADC conversion clock divider, sample capture with pipeline flush, pair packer and output FIFO.
//   state   | meaning
//   PK_LOW  | waiting for the first (low byte) sample of a pair
//   PK_HIGH | low byte held, next accepted sample completes the word
module adc_capture_packer
    import acq_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int DIV        = ACQ_DIV,
    parameter int CAP_PHASE  = ACQ_CAP_PHASE,
    parameter int PIPE_LAT   = ACQ_PIPE_LAT,
    parameter int FIFO_DEPTH = ACQ_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             adc_data,
    input  logic                          clr_overflow,
    output logic                          adc_clk,
    output logic [2*DATA_W-1:0]           out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CNT_W  = $clog2(DIV);
    localparam int SKIP_W = $clog2(PIPE_LAT + 2);

    logic [CNT_W-1:0]  cnt;
    logic [SKIP_W-1:0] skip_cnt;
    logic [DATA_W-1:0] low_byte;
    pack_state_t       state_q;
    pack_state_t       state_d;
    logic              capture;
    logic              accept;
    logic              load_low;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            adc_clk <= 1'b0;
        end else if (!enable) begin
            cnt     <= '0;
            adc_clk <= 1'b0;
        end else begin
            adc_clk <= (cnt < CNT_W'(DIV / 2));
            cnt     <= (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign capture = enable && (cnt == CNT_W'(CAP_PHASE));
    assign accept  = capture && (skip_cnt == '0);

    // Samples still in the ADC pipeline after enable rises are stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt <= SKIP_W'(PIPE_LAT);
        end else if (!enable) begin
            skip_cnt <= SKIP_W'(PIPE_LAT);
        end else if (capture && (skip_cnt != '0)) begin
            skip_cnt <= skip_cnt - SKIP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= PK_LOW;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = PK_LOW;
        end else if (accept) begin
            state_d = (state_q == PK_LOW) ? PK_HIGH : PK_LOW;
        end
    end

    always_comb begin
        load_low = 1'b0;
        push     = 1'b0;
        if (accept) begin
            if (state_q == PK_LOW) load_low = 1'b1;
            else                   push     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        low_byte <= '0;
        else if (load_low) low_byte <= adc_data;
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign drop      = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

    acq_sync_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({adc_data, low_byte}),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );
endmodule
